// File: rtl/mem_access_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data RAM.
// Ports: req/we/size/signExt/addr/wdata in; busy/done/err/rdata out; mem* to RAM.
module mem_access_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  output logic        memRead,
  input  logic [31:0] memReadData
);

  localparam logic [31:0] LIMIT = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD, WR, DONE, ERR
  } state_t;

  state_t      state;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic [1:0]  lat_off;
  logic [31:0] lat_wdata;
  logic [31:0] buffer;

  logic        bad;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] loaded;
  logic [31:0] merged;

  always_comb begin
    unique case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = addr[1:0] != 2'b00;
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= LIMIT) bad = 1'b1;
  end

  // Little-endian lane extraction straight from the RAM read port
  always_comb begin
    rd_byte = memReadData[{lat_off, 3'b000} +: 8];
    rd_half = memReadData[{lat_off[1], 4'b0000} +: 16];
    unique case (lat_size)
      2'b00:   loaded = {{24{lat_sext & rd_byte[7]}}, rd_byte};
      2'b01:   loaded = {{16{lat_sext & rd_half[15]}}, rd_half};
      default: loaded = memReadData;
    endcase
  end

  // Sub-word stores merge into the word captured during RD
  always_comb begin
    merged = buffer;
    unique case (lat_size)
      2'b00:   merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
      2'b01:   merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: merged = lat_wdata;
    endcase
  end

  assign memWriteData = merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      rdata      <= '0;
      memAddress <= '0;
      buffer     <= '0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_sext   <= 1'b0;
      lat_off    <= 2'b00;
      lat_wdata  <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            lat_we     <= we;
            lat_size   <= size;
            lat_sext   <= signExt;
            lat_off    <= addr[1:0];
            lat_wdata  <= wdata;
            memAddress <= {2'b00, addr[31:2]};
            busy       <= 1'b1;
            unique case (1'b1)
              bad: begin
                state <= ERR;
                done  <= 1'b1;
                err   <= 1'b1;
              end
              !bad && we && size == 2'b10: begin
                state    <= WR;
                memWrite <= 1'b1;
              end
              default: begin
                state   <= RD;
                memRead <= 1'b1;
              end
            endcase
          end
        end
        RD: begin
          buffer <= memReadData;
          if (lat_we) begin
            state    <= WR;
            memWrite <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            rdata <= loaded;
          end
        end
        WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed accesses against a small RAM model,
// scoreboarded completions and RAM writes checked by a separate monitor.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        signExt = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata, memAddress, memWriteData, memReadData;
  logic        memWrite, memRead;

  logic [31:0] ram [64];

  int compared = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          reads;
  } exp_t;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] data;
  } wr_t;

  exp_t sb[$];
  wr_t  wq[$];

  mem_access_unit #(.MEM_WORDS(64)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .we(we),
    .size(size),
    .signExt(signExt),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .err(err),
    .rdata(rdata),
    .memAddress(memAddress),
    .memWriteData(memWriteData),
    .memWrite(memWrite),
    .memRead(memRead),
    .memReadData(memReadData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign memReadData = (memAddress < 32'd64) ? ram[memAddress[5:0]] : 32'h0;

  always @(negedge clk)
    if (memWrite && memAddress < 32'd64) ram[memAddress[5:0]] = memWriteData;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a write or done
  initial forever begin
    @(posedge clk);
    #3;
    if (!reset) begin
      rd_cnt = 0;
    end else begin
      if (memRead) rd_cnt++;
      if (memRead || memWrite)
        check("rd_wr_exclusive", {31'b0, memRead & memWrite}, 32'h0);
      if (memWrite) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'h1, 32'h0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("write_index", memAddress, w.idx);
          check("write_data", memWriteData, w.data);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("err", {31'b0, err}, {31'b0, e.err});
          check("rdata", rdata, e.rdata);
          check("latency_cycle", cyc, e.cyc);
          check("read_cycles", rd_cnt, e.reads);
        end
        rd_cnt = 0;
      end
    end
  end

  // Issue one request from IDLE at posedge+1 and return in IDLE at posedge+1
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e, input logic [31:0] rd,
                       input logic [31:0] wv, input int lat,
                       input int nrd, input logic poke);
    int n;
    exp_t x;
    wr_t  y;
    req = 1'b1; we = w; size = sz; signExt = sx; addr = a; wdata = wd;
    x.err = e; x.rdata = rd; x.cyc = cyc + lat; x.reads = nrd;
    sb.push_back(x);
    if (w && !e) begin
      y.idx = {2'b00, a[31:2]};
      y.data = wv;
      wq.push_back(y);
    end
    @(posedge clk); #1;
    req = 1'b0;
    if (poke) begin
      req = 1'b1; we = 1'b1; size = 2'b10; signExt = 1'b1;
      addr = 32'h20; wdata = 32'h12345678;
      @(posedge clk); #1;
      req = 1'b0;
    end
    n = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rw", {30'b0, memRead, memWrite}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", memAddress, 32'h0);
    check("rst_wdata", memWriteData, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", {31'b0, busy}, 32'h0);

    // word round trip at 0x10
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 32'hDEADBEEF, 2, 0, 0);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 32'h0, 2, 1, 0);

    // byte store read-modify-write
    ram[4] = 32'h11223344;
    issue(1, 2'b00, 0, 32'h12, 32'hFFFFFFAB, 0, 32'hDEADBEEF, 32'h11AB3344, 3, 1, 0);
    check("ram4_byte_store", ram[4], 32'h11AB3344);

    // sign/zero extension of sub-word loads
    ram[4] = 32'h80FF7F01;
    issue(0, 2'b00, 1, 32'h12, 32'h0, 0, 32'hFFFFFFFF, 32'h0, 2, 1, 0);
    issue(0, 2'b01, 0, 32'h12, 32'h0, 0, 32'h000080FF, 32'h0, 2, 1, 0);
    issue(0, 2'b00, 0, 32'h13, 32'h0, 0, 32'h00000080, 32'h0, 2, 1, 0);
    issue(0, 2'b00, 1, 32'h13, 32'h0, 0, 32'hFFFFFF80, 32'h0, 2, 1, 0);
    issue(0, 2'b01, 1, 32'h10, 32'h0, 0, 32'h00007F01, 32'h0, 2, 1, 0);
    issue(0, 2'b00, 1, 32'h11, 32'h0, 0, 32'h0000007F, 32'h0, 2, 1, 0);

    // half store into upper half
    issue(1, 2'b01, 0, 32'h12, 32'hCAFEBEEF, 0, 32'h0000007F, 32'hBEEF7F01, 3, 1, 0);

    // errors leave rdata alone and touch no memory
    issue(0, 2'b01, 0, 32'h13, 32'h0, 1, 32'h0000007F, 32'h0, 1, 0, 0);
    issue(1, 2'b10, 0, 32'h102, 32'h55, 1, 32'h0000007F, 32'h0, 1, 0, 0);
    issue(0, 2'b11, 0, 32'h10, 32'h0, 1, 32'h0000007F, 32'h0, 1, 0, 0);
    issue(0, 2'b10, 0, 32'h11, 32'h0, 1, 32'h0000007F, 32'h0, 1, 0, 0);
    issue(0, 2'b10, 0, 32'h100, 32'h0, 1, 32'h0000007F, 32'h0, 1, 0, 0);

    // last valid word
    ram[63] = 32'h0BADF00D;
    issue(0, 2'b10, 0, 32'hFC, 32'h0, 0, 32'h0BADF00D, 32'h0, 2, 1, 0);

    // req while busy is ignored and does not disturb the latched load
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hBEEF7F01, 32'h0, 2, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    check("busy_req_ignored", ram[8], 32'h0);
    check("busy_idle_after", {31'b0, busy}, 32'h0);

    // reset during the WR cycle of a byte store
    ram[4] = 32'h11223344;
    req = 1'b1; we = 1'b1; size = 2'b00; signExt = 1'b0;
    addr = 32'h11; wdata = 32'h000000CD;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("abort_in_wr", {31'b0, memWrite}, 32'h1);
    reset = 1'b0;
    #1;
    check("abort_write_drop", {31'b0, memWrite}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    check("abort_ram4", ram[4], 32'h11223344);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_resume_busy", {31'b0, busy}, 32'h0);
    check("no_resume_ram4", ram[4], 32'h11223344);

    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h11223344, 32'h0, 2, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'h0);
    check("wq_drained", wq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: memAccessUnit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning the number of 32-bit words in the downstream data memory.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-003 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port req, input, 1 bit: access request; sampled only in IDLE.
REQ-005 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 SHALL have port signExt, input, 1 bit: sign-extend sub-word loads when 1, zero-extend when 0.
REQ-008 SHALL have port addr, input, 32 bits: byte address.
REQ-009 SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: valid with done; misaligned, illegal size, or out-of-range access.
REQ-013 SHALL have port rdata, output, 32 bits: extended load result, held until the next done.
REQ-014 SHALL have port memAddress, output, 32 bits: word index to memory, equal to latched addr[31:2].
REQ-015 SHALL have ports memWriteData (output, 32 bits), memWrite (output, 1 bit) and memRead (output, 1 bit).
REQ-016 SHALL have port memReadData, input, 32 bits: combinational memory read data; memory commits writes on negedge clk.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WR, DONE, ERR.
REQ-018 SHALL, in IDLE with req=1, latch we/size/signExt/addr/wdata and transition as follows:
- illegal or misaligned access (size=11; half with addr[0]=1; word with addr[1:0]!=0) or addr[31:2] >= MEM_WORDS -> ERR
- word store -> WR
- all others -> RD
REQ-019 SHALL ignore req while busy=1; latched fields SHALL NOT change until return to IDLE.
REQ-020 SHALL, in RD, drive memRead=1 and memAddress valid, and capture memReadData into an internal word buffer at the closing posedge.
- load -> DONE
- sub-word store -> WR
REQ-021 SHALL, in WR, drive memWrite=1 for exactly one cycle and then go to DONE.
- Word store: memWriteData = wdata.
- Byte store: buffer with lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
- Half store: buffer with bits [16*addr[1]+15 : 16*addr[1]] replaced by wdata[15:0].
REQ-022 SHALL, on the RD->DONE edge for loads, update rdata from the buffered lane (little-endian), extended to 32 bits per signExt; word loads pass unchanged.
REQ-023 SHALL, in DONE, assert done=1 and err=0 for one cycle, then go to IDLE; stores SHALL leave rdata unchanged.
REQ-024 SHALL, in ERR, assert done=1 and err=1 for one cycle with no memRead/memWrite, then go to IDLE; rdata unchanged.
REQ-025 SHALL drive memRead and memWrite low in IDLE, DONE and ERR, and never assert both in the same cycle.
REQ-026 SHALL have latencies from the req-accept edge to the done cycle as follows:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- error: 1 cycle
REQ-027 SHALL accept a new req in the IDLE cycle immediately following DONE/ERR (back-to-back every 3-4 cycles).

Reset
REQ-028 SHALL, while reset=0, immediately force state=IDLE; busy, done, err, memRead and memWrite = 0; rdata, memAddress, memWriteData and the buffer = 0.
REQ-029 SHALL, when reset asserts mid-operation (including during WR before negedge), abort the operation: memWrite drops combinationally and no done pulse follows.
REQ-030 SHALL require req to be sampled again after reset deassertion; an aborted request SHALL NOT resume.

Verification
REQ-031 SHALL cover word round-trip: store word 0xDEADBEEF at addr 0x10, then load word from 0x10 -> memWrite in 1 cycle at memAddress=4; rdata=0xDEADBEEF after 2 cycles.
REQ-032 SHALL cover byte store RMW: mem[4]=0x11223344, store byte 0xAB at addr 0x12 -> one RD then one WR with memWriteData=0x11AB3344.
REQ-033 SHALL cover sign handling: mem[4]=0x80FF7F01, load byte at 0x12 with signExt=1 -> rdata=0xFFFFFFFF; load half at 0x12 with signExt=0 -> rdata=0x000080FF.
REQ-034 SHALL cover error cases: half load at 0x13, word store at 0x102 (index 64), and size=11 -> each gives done=1, err=1 after 1 cycle, with no memRead/memWrite.
REQ-035 SHALL cover abort and busy behaviour: reset=0 during the WR cycle of a byte store -> memory word unchanged, busy=0, no done; also a req pulse while busy -> ignored.
